// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage bridge from the 32-bit pipeline to a 16-bit async SRAM.
// Each load/store becomes two half-word accesses (low half, then high half), each
// held on the bus for WAIT_CYCLES cycles. ready stays low until the word is done.
// Build option: define SRAM_ACCESS_CNT_EN to include the completed-access counter.
module sram_mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic [31:0]        access_cnt
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WLAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic               op_wr_q, op_wr_d;
    logic [SRAM_AW-2:0] wa_q, wa_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               we_n_q, we_n_d;
    logic               oe_q, oe_d;
    logic [SRAM_AW-1:0] saddr_q, saddr_d;
    logic [15:0]        dq_q, dq_d;
    logic               last_s;

    // SRAM word index of a byte address; wraps mod 2^32 and keeps only the low bits.
    function automatic logic [SRAM_AW-2:0] word_addr(input logic [31:0] a);
        word_addr = (SRAM_AW-1)'((a - 32'(ADDR_BASE)) >> 2);
    endfunction

    assign last_s = (wcnt_q == WLAST);

    // Next-state, request latching, per-half wait counting and read-data capture.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        op_wr_d = op_wr_q;
        wa_d    = wa_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = ST_LO;
                    wcnt_d  = {CW{1'b0}};
                    op_wr_d = wr_en;          // write wins over a simultaneous read
                    wa_d    = word_addr(addr);
                    wdata_d = wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                if (last_s) begin
                    state_d = ST_HI;
                    wcnt_d  = {CW{1'b0}};
                    if (!op_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            ST_HI: begin
                if (last_s) begin
                    state_d = ST_DONE;
                    wcnt_d  = {CW{1'b0}};
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                wcnt_d  = {CW{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = {CW{1'b0}};
            end
        endcase
    end

    // Bus values for the coming cycle, derived from the next state so the pads are registered.
    always_comb begin
        we_n_d  = 1'b1;
        oe_d    = 1'b0;
        saddr_d = {SRAM_AW{1'b0}};
        dq_d    = 16'h0000;
        case (state_d)
            ST_LO: begin
                we_n_d  = ~op_wr_d;
                oe_d    = op_wr_d;
                saddr_d = {wa_d, 1'b0};
                dq_d    = op_wr_d ? wdata_d[15:0] : 16'h0000;
            end
            ST_HI: begin
                we_n_d  = ~op_wr_d;
                oe_d    = op_wr_d;
                saddr_d = {wa_d, 1'b1};
                dq_d    = op_wr_d ? wdata_d[31:16] : 16'h0000;
            end
            default: begin
                we_n_d  = 1'b1;
                oe_d    = 1'b0;
                saddr_d = {SRAM_AW{1'b0}};
                dq_d    = 16'h0000;
            end
        endcase
    end

    // State, latched request and bus registers; reset parks the bus in a safe idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= {CW{1'b0}};
            op_wr_q <= 1'b0;
            wa_q    <= {(SRAM_AW-1){1'b0}};
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            we_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            saddr_q <= {SRAM_AW{1'b0}};
            dq_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            op_wr_q <= op_wr_d;
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_n_q  <= we_n_d;
            oe_q    <= oe_d;
            saddr_q <= saddr_d;
            dq_q    <= dq_d;
        end
    end

    assign ready       = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !rd_en && !wr_en);
    assign rdata       = rdata_q;
    assign sram_we_n   = we_n_q;
    assign sram_dq_oe  = oe_q;
    assign sram_addr   = saddr_q;
    assign sram_dq_out = dq_q;

`ifdef SRAM_ACCESS_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // One count per completed access, taken in the DONE cycle; wraps naturally.
    always_comb begin
        if (state_q == ST_DONE) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Access counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'h0000_0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign access_cnt = cnt_q;
`else
    assign access_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl (WAIT_CYCLES=2, ADDR_BASE=1024, SRAM_AW=18).
// A transaction-level model (cycle offset since acceptance, word-level memory) predicts
// every output each cycle; directed scenarios pin the model with literal values.
module tb_sram_mem_ctrl;

    localparam int W     = 2;
    localparam int AW    = 18;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en, wr_en;
    logic [31:0]   addr, wdata, rdata, access_cnt;
    logic          ready, sram_dq_oe, sram_we_n;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;

    sram_mem_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(1024), .SRAM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n), .access_cnt(access_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] sram_mem  [0:DEPTH-1];   // the physical SRAM, written by the DUT bus
    logic [15:0] model_mem [0:DEPTH-1];   // what the SRAM should contain

    assign sram_dq_in = sram_mem[sram_addr];

    int checks = 0;
    int errors = 0;

    // Model: m_k = cycles since acceptance (1..W low half, W+1..2W high half, 2W+1 done)
    bit          m_busy;
    int          m_k;
    bit          m_wr;
    logic [31:0] m_wa, m_wdata, m_rdata, m_cnt;
    bit          last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] half_addr(input logic [31:0] wa, input int hi);
        logic [31:0] t;
        t = wa * 32'd2 + 32'(hi);
        return t[AW-1:0];
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_k     = 0;
        m_rdata = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic compare();
        int ph;
        int hi;
        logic [31:0] exp_cnt;
        ph = !m_busy ? 0 : (m_k <= W ? 1 : (m_k <= 2 * W ? 2 : 3));
        chk("ready", 32'(ready), 32'((ph == 3) || (ph == 0 && !rd_en && !wr_en)));
        if (ph == 1 || ph == 2) begin
            hi = (ph == 2) ? 1 : 0;
            chk("we_n", 32'(sram_we_n), 32'(!m_wr));
            chk("dq_oe", 32'(sram_dq_oe), 32'(m_wr));
            chk("sram_addr", 32'(sram_addr), 32'(half_addr(m_wa, hi)));
            if (m_wr) chk("dq_out", 32'(sram_dq_out), hi ? 32'(m_wdata[31:16]) : 32'(m_wdata[15:0]));
        end else begin
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_dq_oe", 32'(sram_dq_oe), 32'd0);
            chk("idle_addr", 32'(sram_addr), 32'd0);
            chk("idle_dq_out", 32'(sram_dq_out), 32'd0);
        end
        chk("rdata", rdata, m_rdata);
`ifdef SRAM_ACCESS_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'h0;
`endif
        chk("access_cnt", access_cnt, exp_cnt);
    endtask

    task automatic advance();
        logic [AW-1:0] a;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (rd_en || wr_en) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_wr    = wr_en;
                m_wa    = (addr - 32'd1024) >> 2;
                m_wdata = wdata;
            end
        end else begin
            if (m_k == W) begin
                a = half_addr(m_wa, 0);
                if (m_wr) model_mem[a] = m_wdata[15:0];
                else      m_rdata[15:0] = model_mem[a];
            end
            if (m_k == 2 * W) begin
                a = half_addr(m_wa, 1);
                if (m_wr) model_mem[a] = m_wdata[31:16];
                else      m_rdata[31:16] = model_mem[a];
            end
            if (m_k == 2 * W + 1) begin
                m_busy = 1'b0;
                m_cnt  = m_cnt + 32'd1;
            end else begin
                m_k++;
            end
        end
    endtask

    // One clock cycle: drive, compare, advance the model, then let the SRAM take any write.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit rst_mid);
        logic          cap_we;
        logic [AW-1:0] cap_addr;
        logic [15:0]   cap_dq;
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; wdata = d;
        #1;
        compare();
        last_ready = ready;
        cap_we = sram_we_n; cap_addr = sram_addr; cap_dq = sram_dq_out;
        advance();
        if (rst_mid) begin
            rst_n = 1'b0;
            #1;
            chk("rst_we_n", 32'(sram_we_n), 32'd1);
            chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
            chk("rst_addr", 32'(sram_addr), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_ready", 32'(ready), 32'd1);
            model_reset();
        end
        @(posedge clk);
        if (rst_n && cap_we == 1'b0) sram_mem[cap_addr] = cap_dq;
    endtask

    task automatic release_rst();
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int low);
        bit done_now;
        low = 0;
        step(rd, wr, a, d, 1'b0);
        if (!last_ready) low++;
        for (int i = 0; i < 40; i++) begin
            done_now = m_busy && (m_k == 2 * W + 1);
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            if (!last_ready) low++;
            if (done_now) return;
        end
        checks++;
        errors++;
        $display("FAIL op_timeout access did not complete within 40 cycles");
    endtask

    initial begin
        int low;
        int r;
        int diff;
        logic [31:0] ra;
        logic [31:0] exp6;
        int rdy_q[$];

        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i]  = 16'(i * 37) ^ 16'h5A5A;
            model_mem[i] = 16'(i * 37) ^ 16'h5A5A;
        end
        model_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);     // reset state
        release_rst();

        // 1: store, low half then high half, five cycles of ready low
        run_op(1'b0, 1'b1, 32'd1024, 32'h1234ABCD, low);
        chk("t1_ready_low", 32'(low), 32'd5);
        chk("t1_mem0", 32'(sram_mem[0]), 32'h0000ABCD);
        chk("t1_mem1", 32'(sram_mem[1]), 32'h00001234);
        // 2: load back
        run_op(1'b1, 1'b0, 32'd1024, 32'h0, low);
        chk("t2_rdata", rdata, 32'h1234ABCD);
        chk("t2_ready_low", 32'(low), 32'd5);
        // 3: store at next word
        run_op(1'b0, 1'b1, 32'd1028, 32'h55667788, low);
        chk("t3_mem0", 32'(sram_mem[0]), 32'h0000ABCD);
        chk("t3_mem1", 32'(sram_mem[1]), 32'h00001234);
        chk("t3_mem2", 32'(sram_mem[2]), 32'h00007788);
        chk("t3_mem3", 32'(sram_mem[3]), 32'h00005566);
        // 4: read and write together -> write wins
        run_op(1'b1, 1'b1, 32'd1032, 32'hDEADBEEF, low);
        chk("t4_mem4", 32'(sram_mem[4]), 32'h0000BEEF);
        chk("t4_mem5", 32'(sram_mem[5]), 32'h0000DEAD);
        chk("t4_rdata", rdata, 32'h1234ABCD);
        // 5: reset during the high half of a store
        step(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        release_rst();
        run_op(1'b1, 1'b0, 32'd1024, 32'h0, low);
        chk("t5_rdata", rdata, 32'h1234F00D);
        // 6: two loads held back to back after a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        release_rst();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
            if (last_ready) rdy_q.push_back(c);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_ready_count", 32'(rdy_q.size()), 32'd2);
        if (rdy_q.size() >= 2) begin
            chk("t6_done1", 32'(rdy_q[0]), 32'd5);
            chk("t6_done2", 32'(rdy_q[1]), 32'd11);
        end
        chk("t6_rdata", rdata, 32'h55667788);
`ifdef SRAM_ACCESS_CNT_EN
        exp6 = 32'd2;
`else
        exp6 = 32'd0;
`endif
        chk("t6_access_cnt", access_cnt, exp6);

        // Random traffic: requests toggle every cycle, so inputs change mid-access too.
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            else ra = 32'd1024 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            step(r[0], r[1], ra, $urandom, 1'b0);
        end
        for (int n = 0; n < 20 && m_busy; n++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("drain_idle", 32'(m_busy), 32'(1'b0));

        diff = 0;
        for (int i = 0; i < DEPTH; i++) if (sram_mem[i] !== model_mem[i]) diff++;
        chk("mem_image_diffs", 32'(diff), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
